// File: rtl/sdm_pkg.sv
// Shared types and helpers for the sigma-delta link blocks: receiver state
// encoding, CIC register width and the output shift-and-saturate step.
package sdm_pkg;

    typedef enum logic [1:0] {
        XST_IDLE = 2'd0,
        XST_WARM = 2'd1,
        XST_RUN  = 2'd2
    } xst_t;

    // Widest CIC register needed across the legal RLOG range (RLOG <= 8)
    localparam int CIC_WMAX = 18;

    function automatic int cic_w(input int rlog);
        return 2 * rlog + 2;
    endfunction

    // Arithmetic right shift by sh, then clamp to the signed range of a dmsb+1 bit word
    function automatic logic signed [CIC_WMAX-1:0] sat(
        input logic signed [CIC_WMAX-1:0] y,
        input int                         sh,
        input int                         dmsb
    );
        logic signed [CIC_WMAX-1:0] one_v;
        logic signed [CIC_WMAX-1:0] hi_v;
        logic signed [CIC_WMAX-1:0] lo_v;
        logic signed [CIC_WMAX-1:0] s_v;
        one_v    = '0;
        one_v[0] = 1'b1;
        s_v      = y >>> sh;
        hi_v     = (one_v <<< dmsb) - one_v;
        lo_v     = -(one_v <<< dmsb);
        if (s_v > hi_v) begin
            return hi_v;
        end else if (s_v < lo_v) begin
            return lo_v;
        end else begin
            return s_v;
        end
    endfunction

endpackage

// File: rtl/sdm_bit_tick.sv
// Bit-period timebase: free-running period counter with a divider value that
// is only re-sampled at the period boundary, producing one tick per bit.
module sdm_bit_tick #(
    parameter int CMSB = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CMSB:0] div,
    output logic [CMSB:0] cst,
    output logic          tick
);

    logic [CMSB:0] div_r;
    logic [CMSB:0] cst_r;
    logic [CMSB:0] lim_s;
    logic          tick_s;

    // Terminal count: a zero divider behaves like one so the period never drops below 2 clk
    always_comb begin
        lim_s  = div_r;
        tick_s = 1'b0;
        if (div_r == {(CMSB+1){1'b0}}) begin
            lim_s = {{CMSB{1'b0}}, 1'b1};
        end else begin
            lim_s = div_r;
        end
        if (en && (cst_r == lim_s)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Period counter; div is captured while idle and at every wrap only
    always_ff @(posedge clk) begin
        if (rst) begin
            cst_r <= {(CMSB+1){1'b0}};
            div_r <= {(CMSB+1){1'b0}};
        end else if (!en) begin
            cst_r <= {(CMSB+1){1'b0}};
            div_r <= div;
        end else if (tick_s) begin
            cst_r <= {(CMSB+1){1'b0}};
            div_r <= div;
        end else begin
            cst_r <= cst_r + {{CMSB{1'b0}}, 1'b1};
        end
    end

    assign cst  = cst_r;
    assign tick = tick_s;

endmodule

// File: rtl/sdm_cic_rx.sv
// Sigma-delta receiver: synchronised bit recovery, 2nd-order CIC decimation by
// 2^RLOG, scale/saturate, and a one-entry sample buffer with toggle-pop handshake.
module sdm_cic_rx
    import sdm_pkg::*;
#(
    parameter int DMSB = 3,
    parameter int CMSB = 12,
    parameter int RLOG = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          setn,
    input  logic [CMSB:0] div,
    input  logic          rx,
    input  logic          pop,
    input  logic          clear,
    output logic [DMSB:0] rdata,
    output logic          full,
    output logic          ovf,
    output logic [1:0]    xst,
    output logic [CMSB:0] cst
);

    localparam int W  = cic_w(RLOG);
    localparam int SH = 2 * RLOG - DMSB;

    logic                 rx_m_r;
    logic                 rx_s_r;
    logic                 tick_s;

    logic signed [W-1:0]  i1_r;
    logic signed [W-1:0]  i2_r;
    logic signed [W-1:0]  i2_z_r;
    logic signed [W-1:0]  c1_r;
    logic signed [W-1:0]  y_r;
    logic [RLOG-1:0]      dcnt_r;
    logic                 dec_r;
    logic                 ld_r;
    logic                 wcnt_r;

    logic signed [W-1:0]  x_s;
    logic signed [W-1:0]  i1_nx_s;
    logic signed [W-1:0]  i2_nx_s;
    logic signed [W-1:0]  c1_nx_s;
    logic signed [W-1:0]  y_nx_s;
    logic signed [DMSB:0] smp_s;

    xst_t                 state_r;
    xst_t                 state_s;

    logic [DMSB:0]        rdata_r;
    logic                 full_r;
    logic                 ovf_r;
    logic                 pop_d_r;
    logic                 pop_edge_s;

    sdm_bit_tick #(
        .CMSB (CMSB)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (setn),
        .div  (div),
        .cst  (cst),
        .tick (tick_s)
    );

    // Two-flop synchroniser for the asynchronous bitstream
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m_r <= 1'b0;
            rx_s_r <= 1'b0;
        end else begin
            rx_m_r <= rx;
            rx_s_r <= rx_m_r;
        end
    end

    // Integrator and comb arithmetic, all modulo 2^W
    always_comb begin
        x_s     = {W{1'b1}};
        if (rx_s_r) begin
            x_s = {{(W-1){1'b0}}, 1'b1};
        end else begin
            x_s = {W{1'b1}};
        end
        i1_nx_s = i1_r + x_s;
        i2_nx_s = i2_r + i1_nx_s;
        c1_nx_s = i2_r - i2_z_r;
        y_nx_s  = c1_nx_s - c1_r;
        smp_s   = (DMSB+1)'(sat(CIC_WMAX'(y_r), SH, DMSB));
    end

    // CIC pipeline: integrate on tick, comb one clk after the decimation tick, load one clk later
    always_ff @(posedge clk) begin
        if (rst || !setn) begin
            i1_r   <= {W{1'b0}};
            i2_r   <= {W{1'b0}};
            i2_z_r <= {W{1'b0}};
            c1_r   <= {W{1'b0}};
            y_r    <= {W{1'b0}};
            dcnt_r <= {RLOG{1'b0}};
            dec_r  <= 1'b0;
            ld_r   <= 1'b0;
            wcnt_r <= 1'b0;
        end else begin
            dec_r <= tick_s && (dcnt_r == {RLOG{1'b1}});
            ld_r  <= dec_r && (state_r == XST_RUN);
            if (tick_s) begin
                i1_r   <= i1_nx_s;
                i2_r   <= i2_nx_s;
                dcnt_r <= dcnt_r + {{(RLOG-1){1'b0}}, 1'b1};
            end
            if (dec_r) begin
                i2_z_r <= i2_r;
                c1_r   <= c1_nx_s;
                y_r    <= y_nx_s;
            end
            if (dec_r && (state_r == XST_WARM)) begin
                wcnt_r <= 1'b1;
            end
        end
    end

    // Next state: warm-up swallows two decimation outputs before running
    always_comb begin
        state_s = state_r;
        case (state_r)
            XST_IDLE: begin
                if (setn) state_s = XST_WARM;
                else      state_s = XST_IDLE;
            end
            XST_WARM: begin
                if (!setn)                 state_s = XST_IDLE;
                else if (dec_r && wcnt_r)  state_s = XST_RUN;
                else                       state_s = XST_WARM;
            end
            XST_RUN: begin
                if (!setn) state_s = XST_IDLE;
                else       state_s = XST_RUN;
            end
            default: state_s = XST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= XST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    assign pop_edge_s = (pop != pop_d_r);

    // Pop toggle history; reset preloads it so a held pop level is not an edge
    always_ff @(posedge clk) begin
        pop_d_r <= pop;
    end

    // One-entry buffer: load beats a simultaneous pop, a load into a full buffer sets ovf
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {(DMSB+1){1'b0}};
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (!setn || (state_r == XST_IDLE) || clear) begin
            full_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (ld_r) begin
            if (full_r && !pop_edge_s) begin
                ovf_r <= 1'b1;
            end else begin
                rdata_r <= smp_s;
                full_r  <= 1'b1;
            end
        end else if (pop_edge_s) begin
            full_r <= 1'b0;
        end
    end

    assign rdata = rdata_r;
    assign full  = full_r;
    assign ovf   = ovf_r;
    assign xst   = state_r;

endmodule

// File: tb/tb_sdm_cic_rx.sv
// Directed bench for sdm_cic_rx: reset, constant/alternating/modulated
// bitstreams, exact sample latency and spacing, overrun, clear and disable.
module tb_sdm_cic_rx;

    logic        clk;
    logic        rst;
    logic        setn;
    logic [12:0] div;
    logic        rx;
    logic        pop;
    logic        clear;
    logic [3:0]  rdata;
    logic        full;
    logic        ovf;
    logic [1:0]  xst;
    logic [12:0] cst;

    int n_chk;
    int n_err;
    int cyc;

    int gen_mode;
    int gen_bit;
    int gen_per;
    int gen_cnt;
    int gen_acc;

    sdm_cic_rx dut (
        .clk   (clk),
        .rst   (rst),
        .setn  (setn),
        .div   (div),
        .rx    (rx),
        .pop   (pop),
        .clear (clear),
        .rdata (rdata),
        .full  (full),
        .ovf   (ovf),
        .xst   (xst),
        .cst   (cst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_full(input string tag, input int budget, output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (full !== 1'b1 && c < budget);
        chk({tag, "_rise"}, full, 1);
    endtask

    // Bitstream source: constant, 1010..., or first-order modulator of +2/8 full scale
    task automatic rx_gen();
        forever begin
            @(negedge clk);
            if (gen_mode == 0) begin
                rx = gen_bit[0];
                gen_cnt = 0;
            end else if (gen_cnt >= gen_per - 1) begin
                gen_cnt = 0;
                if (gen_mode == 1) begin
                    rx = ~rx;
                end else begin
                    rx = (gen_acc >= 0);
                    gen_acc = gen_acc + 2 - (rx ? 8 : -8);
                end
            end else begin
                gen_cnt++;
            end
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        gen_mode = 0; gen_bit = 1; gen_per = 5; gen_cnt = 0; gen_acc = 0;
        rx = 1'b0; rst = 1'b1; setn = 1'b0; div = 13'd4; pop = 1'b0; clear = 1'b0;
        fork
            rx_gen();
        join_none

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            setn  = 1'($urandom_range(1));
            pop   = 1'($urandom_range(1));
            clear = 1'($urandom_range(1));
            div   = 13'($urandom_range(8191));
            gen_bit = $urandom_range(1);
            @(negedge clk);
        end
        chk("rst_rdata", $signed(rdata), 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_xst", xst, 0);
        chk("rst_cst", cst, 0);
        rst = 1'b0; setn = 1'b0; clear = 1'b0; div = 13'd4; gen_mode = 0; gen_bit = 1;
        step(6);
        chk("idle_cst", cst, 0);

        // Constant ones, div=4: first sample after 48 ticks + 2 clk
        setn = 1'b1;
        step(1);
        chk("c1_cst_first", cst, 1);
        chk("c1_xst_warm", xst, 1);
        step(240);
        chk("c1_full_early", full, 0);
        chk("c1_xst_run", xst, 2);
        step(1);
        chk("c1_full_on_time", full, 1);
        chk("c1_rdata", $signed(rdata), 7);

        // Disable clears full; constant zeros give -8
        setn = 1'b0;
        step(1);
        chk("c0_xst_idle", xst, 0);
        chk("c0_full_clr", full, 0);
        gen_bit = 0;
        step(4);
        setn = 1'b1;
        wait_full("c0_a", 400, cyc);
        chk("c0_lat", cyc, 242);
        chk("c0_rdata_a", $signed(rdata), -8);
        pop = ~pop;
        step(1);
        chk("c0_pop_full", full, 0);
        chk("c0_pop_ovf", ovf, 0);
        wait_full("c0_b", 200, cyc);
        chk("c0_rdata_b", $signed(rdata), -8);
        chk("c0_ovf_b", ovf, 0);

        // Alternating bits, div=7: values in {-1,0}, spacing 128 clk
        setn = 1'b0; div = 13'd7; gen_per = 8; gen_mode = 1;
        step(4);
        setn = 1'b1;
        wait_full("alt_a", 600, cyc);
        chk("alt_val_a", ($signed(rdata) == 0 || $signed(rdata) == -1), 1);
        pop = ~pop;
        wait_full("alt_b", 200, cyc);
        chk("alt_spacing", cyc, 128);
        chk("alt_val_b", ($signed(rdata) == 0 || $signed(rdata) == -1), 1);

        // Overrun, pop, clear, then load colliding with a pop edge
        setn = 1'b0; div = 13'd4; gen_per = 5; gen_mode = 0; gen_bit = 1;
        step(4);
        setn = 1'b1;
        wait_full("ovr_a", 400, cyc);
        chk("ovr_rdata_a", $signed(rdata), 7);
        step(79);
        chk("ovr_before", ovf, 0);
        step(1);
        chk("ovr_set", ovf, 1);
        chk("ovr_full", full, 1);
        chk("ovr_hold", $signed(rdata), 7);
        pop = ~pop;
        step(1);
        chk("ovr_pop_full", full, 0);
        chk("ovr_pop_ovf", ovf, 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_ovf", ovf, 0);
        wait_full("clr_next", 200, cyc);
        chk("clr_next_lat", cyc, 78);
        step(79);
        pop = ~pop;
        step(1);
        chk("coll_full", full, 1);
        chk("coll_ovf", ovf, 0);
        step(1);
        chk("coll_full_hold", full, 1);

        // Drop setn with dcnt=7, then restart with fresh warm-up
        step(33);
        setn = 1'b0;
        step(1);
        chk("dis_xst", xst, 0);
        chk("dis_cst", cst, 0);
        chk("dis_full", full, 0);
        setn = 1'b1;
        wait_full("ren", 400, cyc);
        chk("ren_lat", cyc, 242);
        chk("ren_rdata", $signed(rdata), 7);

        // Modulated stream encoding +2
        setn = 1'b0; gen_acc = 0; gen_cnt = 0; gen_mode = 2;
        step(4);
        setn = 1'b1;
        wait_full("lb_a", 400, cyc);
        chk("lb_val_a", ($signed(rdata) >= 1 && $signed(rdata) <= 3), 1);
        for (int k = 0; k < 2; k++) begin
            pop = ~pop;
            wait_full("lb_n", 200, cyc);
            chk("lb_val_n", ($signed(rdata) >= 1 && $signed(rdata) <= 3), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
